// File: rtl/correlation_barker_wrapper_pkg.sv
// Shared constants and types for the Barker-13 correlator: reference word,
// architecture selector, match-count type and the registered output beat.
package barker_pkg;

  localparam int BARKER_LEN = 13;
  localparam logic [BARKER_LEN-1:0] BARKER13 = 13'b1111100110101;

  typedef enum logic [0:0] {
    ARCH_POPCOUNT   = 1'b0,
    ARCH_ADDER_TREE = 1'b1
  } arch_e;

  typedef logic [3:0] match_t;

  typedef struct packed {
    logic vld;
    logic dat;
  } det_beat_t;

  // Bit i is set where the window chip agrees with the reference chip at i.
  function automatic logic [BARKER_LEN-1:0] chip_agree(input logic [BARKER_LEN-1:0] win);
    return ~(win ^ BARKER13);
  endfunction

endpackage

// File: rtl/axis_1bit.sv
// Minimal 1-bit AXI-Stream link: tdata, tvalid, tready only.
interface axis_1bit;
  logic [0:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/correlation_barker_core.sv
// Window -> agreeing-chip count, purely combinational (zero latency, no flow control).
// ARCH_TYPE picks a behavioural popcount or an explicit balanced adder tree.
module correlation_barker_core
  import barker_pkg::*;
#(
  parameter int ARCH_TYPE = 0
) (
  input  logic [BARKER_LEN-1:0] i_window,
  output match_t                o_matches
);

  logic [BARKER_LEN-1:0] w_agree;
  assign w_agree = chip_agree(i_window);

  if (ARCH_TYPE == int'(ARCH_ADDER_TREE)) begin : g_tree
    logic [1:0] w_l1 [6];
    logic [2:0] w_l2 [3];
    logic [3:0] w_l3a;
    logic [2:0] w_l3b;

    for (genvar k = 0; k < 6; k++) begin : g_l1
      assign w_l1[k] = {1'b0, w_agree[2*k]} + {1'b0, w_agree[2*k+1]};
    end
    for (genvar k = 0; k < 3; k++) begin : g_l2
      assign w_l2[k] = {1'b0, w_l1[2*k]} + {1'b0, w_l1[2*k+1]};
    end

    // Odd chip out (bit 12) joins the shallow branch; max 4+1 fits 3 bits.
    assign w_l3a     = {1'b0, w_l2[0]} + {1'b0, w_l2[1]};
    assign w_l3b     = w_l2[2] + {2'b00, w_agree[12]};
    assign o_matches = w_l3a + {1'b0, w_l3b};
  end else begin : g_pop
    match_t w_count;

    always_comb begin
      w_count = '0;
      for (int i = 0; i < BARKER_LEN; i++) begin
        w_count = w_count + {3'b000, w_agree[i]};
      end
    end

    assign o_matches = w_count;
  end

endmodule

// File: rtl/correlation_barker_wrapper.sv
// Barker-13 detector on a 1-bit chip stream: one output beat per input beat, 1-clock latency.
// Single registered output stage; s_axis.tready drops only while that stage is full and stalled.
module correlation_barker_wrapper
  import barker_pkg::*;
#(
  parameter int ARCH_TYPE = 0,
  parameter int MATCH_MIN = 13
) (
  input  logic     i_clk,
  input  logic     i_rst,
  axis_1bit.slave  s_axis,
  axis_1bit.master m_axis
);

  // Only the 12 most recent chips are stored; the incoming chip completes the window.
  logic [BARKER_LEN-2:0] r_hist;
  det_beat_t             r_out;

  logic                  w_s_rdy;
  logic                  w_accept;
  logic [BARKER_LEN-1:0] w_window;
  match_t                w_matches;
  logic                  w_detect;

  assign w_s_rdy  = !r_out.vld || m_axis.tready;
  assign w_accept = s_axis.tvalid && w_s_rdy;
  assign w_window = {r_hist, s_axis.tdata[0]};
  assign w_detect = (w_matches >= 4'(MATCH_MIN));

  correlation_barker_core #(
    .ARCH_TYPE(ARCH_TYPE)
  ) u_core (
    .i_window (w_window),
    .o_matches(w_matches)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hist    <= '0;
      r_out.vld <= 1'b0;
      r_out.dat <= 1'b0;
    end else if (w_accept) begin
      r_hist    <= w_window[BARKER_LEN-2:0];
      r_out.vld <= 1'b1;
      r_out.dat <= w_detect;
    end else if (m_axis.tready) begin
      r_out.vld <= 1'b0;
    end
  end

  assign s_axis.tready = w_s_rdy;
  assign m_axis.tvalid = r_out.vld;
  assign m_axis.tdata  = r_out.dat;

endmodule

// File: tb/tb_correlation_barker_wrapper.sv
// Directed bench for the Barker-13 correlator: three lockstep DUTs
// (popcount/13, adder tree/13, adder tree/12) driven by the same stream.
module tb_correlation_barker_wrapper;

  localparam logic [12:0] REF_WORD = 13'b1111100110101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_vld;
  logic in_dat;
  logic out_rdy;

  axis_1bit s0 (), m0 (), s1 (), m1 (), s2 (), m2 ();

  assign s0.tvalid = in_vld;
  assign s1.tvalid = in_vld;
  assign s2.tvalid = in_vld;
  assign s0.tdata  = in_dat;
  assign s1.tdata  = in_dat;
  assign s2.tdata  = in_dat;
  assign m0.tready = out_rdy;
  assign m1.tready = out_rdy;
  assign m2.tready = out_rdy;

  correlation_barker_wrapper #(.ARCH_TYPE(0), .MATCH_MIN(13)) u_d0 (
    .i_clk(clk), .i_rst(rst), .s_axis(s0), .m_axis(m0));
  correlation_barker_wrapper #(.ARCH_TYPE(1), .MATCH_MIN(13)) u_d1 (
    .i_clk(clk), .i_rst(rst), .s_axis(s1), .m_axis(m1));
  correlation_barker_wrapper #(.ARCH_TYPE(1), .MATCH_MIN(12)) u_d2 (
    .i_clk(clk), .i_rst(rst), .s_axis(s2), .m_axis(m2));

  int n_checks = 0;
  int n_pass   = 0;

  logic [12:0] m_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int ref_matches(input logic [12:0] w);
    logic [12:0] r;
    int c;
    r = REF_WORD;
    c = 0;
    for (int i = 0; i < 13; i++) if (w[i] == r[i]) c++;
    return c;
  endfunction

  // Called just after a rising edge; leaves the bench just after a later rising edge.
  task automatic do_reset();
    rst    = 1'b1;
    in_vld = 1'b0;
    in_dat = 1'b0;
    #1;
    chk("rst m_tvalid", m0.tvalid, 0);
    chk("rst m_tdata", m0.tdata, 0);
    chk("rst s_tready", s0.tready, 1);
    chk("rst m_tvalid arch1", m1.tvalid, 0);
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_win = '0;
  endtask

  task automatic send_seq(input logic [12:0] seq, input int n,
                          input logic [12:0] e13, input logic [12:0] e12, input string tag);
    for (int i = 0; i < n; i++) begin
      in_vld = 1'b1;
      in_dat = seq[12-i];
      @(posedge clk);
      #1;
      chk({tag, " vld"}, m0.tvalid, 1);
      chk({tag, " dat a0"}, m0.tdata, e13[12-i]);
      chk({tag, " dat a1"}, m1.tdata, e13[12-i]);
      chk({tag, " dat m12"}, m2.tdata, e12[12-i]);
    end
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " idle"}, m0.tvalid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:0] chips [40];
    bit   q13 [$];
    bit   q12 [$];
    logic [12:0] bw;
    int   n_out, mt, idx, cyc, det_seen, n_pop;
    bit   exp_full, prev_stall, prev_dat, acc;

    rst     = 1'b1;
    in_vld  = 1'b0;
    in_dat  = 1'b0;
    out_rdy = 1'b1;
    do_reset();

    // Clean Barker word: detection only on the 13th chip for every DUT.
    send_seq(13'b1111100110101, 13, 13'b0000000000001, 13'b0000000000001, "barker");

    // 7th chip flipped: 12 matches, seen only by the MATCH_MIN=12 instance.
    do_reset();
    send_seq(13'b1111101110101, 13, 13'b0, 13'b0000000000001, "flip7");

    // All ones: final window has 9 matches, no detection anywhere.
    do_reset();
    send_seq(13'b1111111111111, 13, 13'b0, 13'b0, "ones");

    // Reset mid-word with a stalled pending beat, then a full word.
    do_reset();
    send_seq(13'b1111100110101, 7, 13'b0, 13'b0, "pre7");
    in_vld  = 1'b1;
    in_dat  = 1'b1;
    out_rdy = 1'b0;
    @(posedge clk);
    #1;
    chk("pend vld", m0.tvalid, 1);
    chk("pend s_tready", s0.tready, 0);
    do_reset();
    send_seq(13'b1111100110101, 13, 13'b0000000000001, 13'b0000000000001, "post");

    // Continuous random stream at full throughput.
    do_reset();
    n_out = 0;
    for (int i = 0; i < 1000; i++) begin
      in_vld = 1'b1;
      in_dat = 1'($urandom_range(0, 1));
      @(posedge clk);
      m_win = {m_win[11:0], in_dat};
      #1;
      if (m0.tvalid) n_out++;
      mt = ref_matches(m_win);
      chk("rand a0", m0.tdata, (mt >= 13) ? 1 : 0);
      chk("rand a1", m1.tdata, (mt >= 13) ? 1 : 0);
      chk("rand m12", m2.tdata, (mt >= 12) ? 1 : 0);
    end
    in_vld = 1'b0;
    chk("rand out count", n_out, 1000);

    // Random backpressure and gaps with a Barker word embedded.
    do_reset();
    bw = REF_WORD;
    for (int i = 0; i < 40; i++) begin
      if (i >= 15 && i < 28) chips[i] = bw[27-i];
      else chips[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; cyc = 0; det_seen = 0; n_pop = 0;
    prev_stall = 1'b0; prev_dat = 1'b0;
    while ((idx < 40 || q13.size() != 0) && cyc < 2000) begin
      in_vld  = (idx < 40) ? ($urandom_range(0, 3) != 0) : 1'b0;
      in_dat  = (idx < 40) ? chips[idx] : 1'b0;
      out_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_full = (q13.size() != 0);
      if (prev_stall) begin
        chk("stall vld", m0.tvalid, 1);
        chk("stall dat", m0.tdata, prev_dat);
      end
      chk("bp m_tvalid", m0.tvalid, exp_full);
      chk("bp s_tready", s0.tready, (!exp_full || out_rdy) ? 1 : 0);
      prev_stall = exp_full && !out_rdy;
      if (exp_full) prev_dat = q13[0];
      if (exp_full && out_rdy) begin
        chk("bp dat a0", m0.tdata, q13[0]);
        chk("bp dat a1", m1.tdata, q13[0]);
        chk("bp dat m12", m2.tdata, q12[0]);
        if (q13[0]) det_seen++;
        void'(q13.pop_front());
        void'(q12.pop_front());
        n_pop++;
      end
      acc = in_vld && (!exp_full || out_rdy);
      if (acc) begin
        m_win = {m_win[11:0], in_dat};
        mt = ref_matches(m_win);
        q13.push_back(mt >= 13);
        q12.push_back(mt >= 12);
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp all sent", idx, 40);
    chk("bp beats out", n_pop, 40);
    chk("bp detect seen", (det_seen >= 1) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/correlation_barker_wrapper.md
CORRELATION_BARKER_WRAPPER -- requirements
Module: correlation_barker_wrapper

Interface
REQ-001 SHALL have parameter ARCH_TYPE, default 0: 0 = parallel XNOR + popcount, 1 = XNOR + registered-free adder tree; both SHALL give bit-identical, cycle-identical outputs.
REQ-002 SHALL have parameter MATCH_MIN, default 13, legal range 7..13: minimum agreeing chips for a detection.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  sole clock, all state on rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 s_axis  axis_1bit.slave  -  input chip stream: tdata[0:0] in, tvalid in, tready out.
REQ-007 m_axis  axis_1bit.master  -  detection stream: tdata[0:0] out, tvalid out, tready in.
REQ-008 axis_1bit SHALL carry exactly tdata (1 bit), tvalid, tready, with master/slave modports.

Function
REQ-009 Chip mapping: tdata 1 = +1, tdata 0 = -1.
REQ-010 Reference: Barker-13 = 1111100110101, leftmost chip received first.
REQ-011 A beat is accepted when s_axis.tvalid && s_axis.tready at a rising edge.
REQ-012 Each accepted beat SHALL shift into a 13-bit window; newest at bit 0, oldest at bit 12.
REQ-013 matches = count of window bits equal to the Barker bit in the same position (4-bit, 0..13); correlation = 2*matches - 13.
REQ-014 Each accepted input beat SHALL produce exactly one output beat; no beats created, dropped or reordered.
REQ-015 Output beat SHALL be registered: m_axis.tvalid rises the edge the input is accepted; tdata = 1 iff matches (on the updated window) >= MATCH_MIN.
REQ-016 Latency: one clock from input acceptance to output tvalid.
REQ-017 s_axis.tready = !m_axis.tvalid || m_axis.tready (combinational, single output stage).
REQ-018 m_axis.tvalid/tdata SHALL hold stable while tvalid && !tready.
REQ-019 Simultaneous output handshake and new input acceptance in one cycle SHALL load the new beat with no bubble (full throughput, 1 beat/clock).
REQ-020 Warm-up: window reset to all zeros (correlation -5); first 12 outputs after reset SHALL be evaluated on the zero-filled window with no special casing.
REQ-021 No detection suppression: overlapping/adjacent matches each assert tdata on their own beat.

Reset
REQ-022 While i_rst high: window = 0, m_axis.tvalid = 0, m_axis.tdata = 0, s_axis.tready = 1.
REQ-023 Reset asserted mid-stream SHALL discard the window and any pending output beat immediately.
REQ-024 First acceptance possible on the first rising edge after i_rst deasserts.

Structure
REQ-025 Package barker_pkg SHALL hold BARKER13 constant (13'b1111100110101), BARKER_LEN = 13, arch_e enum (ARCH_POPCOUNT = 0, ARCH_ADDER_TREE = 1).
REQ-026 One sub-module correlation_barker_core: combinational window -> matches, architecture chosen by ARCH_TYPE via generate.
REQ-027 axis_1bit interface is shared infrastructure, not part of this block.

Verification
REQ-028 Reset, then 13 beats 1,1,1,1,1,0,0,1,1,0,1,0,1 with tready = 1 -> 13 outputs, only the 13th has tdata = 1, each one clock after its input.
REQ-029 Same sequence with the 7th chip flipped (0 -> 1), MATCH_MIN = 13 -> all tdata 0; MATCH_MIN = 12 -> 13th output tdata = 1.
REQ-030 Continuous 1000-beat random stream, tready = 1 -> output count 1000, tdata equals reference model (window popcount) each beat, both ARCH_TYPE values.
REQ-031 Random m_axis.tready (50%) with a Barker word embedded -> no beat lost or duplicated, tdata stable during stall, s_axis.tready low only when output is full and stalled.
REQ-032 Assert i_rst after 7 Barker chips, release, send full Barker word -> no false detection, detection exactly on its 13th chip.
REQ-033 All-ones stream of 13 beats -> all outputs tdata 0 (matches = 9).
